// File: rtl/flow_route_scheduler.sv
// Two-chain flow outlet scheduler: round-robin grant, route check, settle/flow/flush sequencing; first out_en SETTLE_CYC+1 cycles after acceptance.
// Backpressure: src_ready only while IDLE, so a pending request simply waits until the current job has been released.
module flow_route_scheduler #(
   parameter int SETTLE_CYC = 8,
   parameter int FLUSH_CYC  = 4,
   parameter int DUR_W      = 8,
   parameter int STAGES     = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              src_valid,
   output logic [1:0]              src_ready,
   input  logic [2*2*STAGES-1:0]   src_route,
   input  logic [2*DUR_W-1:0]      src_dur,
   input  logic                    abort,
   output logic [2*STAGES-1:0]     sw_cfg_a,
   output logic [2*STAGES-1:0]     sw_cfg_b,
   output logic                    out_sel,
   output logic                    out_en,
   output logic                    busy,
   output logic                    done,
   output logic                    done_src,
   output logic                    err
);
   localparam int RW = 2*STAGES;
   localparam int CW = (DUR_W < 8) ? 8 : DUR_W;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, SETTLE, FLOW, FLUSH} state_t;

   typedef struct packed {
      logic             src;
      logic [DUR_W-1:0] dur;
   } job_t;

   state_t           state;
   job_t             job;
   logic             rr_ptr;
   logic [CW-1:0]    cnt;
   logic [1:0]       grant;
   logic             acc;
   logic             acc_src;
   logic [RW-1:0]    acc_route;
   logic [DUR_W-1:0] acc_dur;

   // A stage must be open, and at most one stage may divert into a unit.
   function automatic logic route_legal(input logic [RW-1:0] r);
      int   units;
      logic ok;
      units = 0;
      ok    = 1'b1;
      for (int k = 0; k < STAGES; k++) begin
         if (r[2*k +: 2] == 2'd0) ok = 1'b0;
         if (r[2*k+1]) units++;
      end
      return ok && (units <= 1);
   endfunction

   always_comb begin
      grant = src_valid;
      if (src_valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
   end

   assign src_ready = (state == IDLE) ? grant : 2'b00;
   assign acc       = |(src_valid & src_ready);
   assign acc_src   = src_ready[1];
   assign acc_route = acc_src ? src_route[2*RW-1:RW] : src_route[RW-1:0];
   assign acc_dur   = acc_src ? src_dur[2*DUR_W-1:DUR_W] : src_dur[DUR_W-1:0];
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         job      <= '0;
         rr_ptr   <= 1'b0;
         cnt      <= '0;
         sw_cfg_a <= '0;
         sw_cfg_b <= '0;
         out_sel  <= 1'b0;
         out_en   <= 1'b0;
         done     <= 1'b0;
         done_src <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (acc) begin
                  rr_ptr <= ~acc_src;
                  if (route_legal(acc_route)) begin
                     job.src  <= acc_src;
                     job.dur  <= acc_dur;
                     sw_cfg_a <= acc_src ? '0 : acc_route;
                     sw_cfg_b <= acc_src ? acc_route : '0;
                     out_sel  <= acc_src;
                     cnt      <= CW'(SETTLE_CYC);
                     state    <= SETTLE;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            SETTLE: begin
               if (abort) begin
                  cnt   <= CW'(FLUSH_CYC);
                  state <= FLUSH;
               end else if (cnt == CNT_ONE) begin
                  out_en <= 1'b1;
                  cnt    <= (job.dur == '0) ? CNT_ONE : CW'(job.dur);
                  state  <= FLOW;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FLOW: begin
               if (abort || cnt == CNT_ONE) begin
                  out_en <= 1'b0;
                  cnt    <= CW'(FLUSH_CYC);
                  state  <= FLUSH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FLUSH: begin
               if (cnt == CNT_ONE) begin
                  sw_cfg_a <= '0;
                  sw_cfg_b <= '0;
                  done     <= 1'b1;
                  done_src <= job.src;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_flow_route_scheduler.sv
// Scoreboard bench for flow_route_scheduler: accepted jobs are queued with their expected timing
// and retired against err/out_en/done activity observed on the falling edge.
module tb_flow_route_scheduler;
   localparam int SETTLE_CYC = 8;
   localparam int FLUSH_CYC  = 4;
   localparam int DUR_W      = 8;
   localparam int STAGES     = 5;
   localparam int RW         = 2*STAGES;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [1:0]            src_valid = 2'b00;
   logic [1:0]            src_ready;
   logic [2*RW-1:0]       src_route;
   logic [2*DUR_W-1:0]    src_dur;
   logic                  abort = 1'b0;
   logic [RW-1:0]         sw_cfg_a, sw_cfg_b;
   logic                  out_sel, out_en, busy, done, done_src, err;
   logic [RW-1:0]         rt [2];
   logic [DUR_W-1:0]      du [2];

   assign src_route = {rt[1], rt[0]};
   assign src_dur   = {du[1], du[0]};

   always #5 clk = ~clk;

   flow_route_scheduler #(
      .SETTLE_CYC(SETTLE_CYC), .FLUSH_CYC(FLUSH_CYC), .DUR_W(DUR_W), .STAGES(STAGES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
      .src_route(src_route), .src_dur(src_dur), .abort(abort),
      .sw_cfg_a(sw_cfg_a), .sw_cfg_b(sw_cfg_b), .out_sel(out_sel), .out_en(out_en),
      .busy(busy), .done(done), .done_src(done_src), .err(err)
   );

   typedef struct {
      int             src;
      logic [RW-1:0]  route;
      int             edur;
      bit             legal;
      int             acc;
   } job_t;

   job_t sb[$];
   int   grants[$];
   int   n_chk = 0, n_pass = 0, cyc = 0;
   int   rise_cyc = 0, fall_cyc = 0;
   bit   prev_en = 1'b0, abort_plan = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   function automatic bit legal(input logic [RW-1:0] r);
      int       units;
      logic [1:0] c;
      units = 0;
      for (int k = 0; k < STAGES; k++) begin
         c = r[2*k +: 2];
         if (c == 2'd0) return 1'b0;
         if (c >= 2'd2) units++;
      end
      return units < 2;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      job_t j;
      if (!rst_n) begin
         sb.delete();
         prev_en = 1'b0;
      end else begin
         if (err) begin
            chk("err_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               j = sb.pop_front();
               chk("err_on_illegal", j.legal, 0);
               chk("err_latency", cyc - j.acc, 1);
            end
         end
         if (out_en && !prev_en) begin
            chk("flow_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               j = sb[0];
               rise_cyc = cyc;
               chk("flow_start_lat", cyc - j.acc, SETTLE_CYC + 1);
               chk("cfg_granted", j.src ? sw_cfg_b : sw_cfg_a, j.route);
               chk("cfg_idle_chain", j.src ? sw_cfg_a : sw_cfg_b, 0);
               chk("out_sel", out_sel, j.src);
               chk("busy_in_flow", busy, 1);
            end
         end
         if (!out_en && prev_en && sb.size() > 0) begin
            fall_cyc = cyc;
            chk("flow_len", cyc - rise_cyc, sb[0].edur);
         end
         if (done) begin
            chk("done_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               j = sb.pop_front();
               chk("done_legal", j.legal, 1);
               chk("done_src", done_src, j.src);
               chk("flush_len", cyc - fall_cyc, FLUSH_CYC);
               chk("done_cfg_a", sw_cfg_a, 0);
               chk("done_cfg_b", sw_cfg_b, 0);
               chk("done_busy", busy, 0);
            end
         end
         if (|(src_valid & src_ready)) begin
            chk("ready_onehot", $countones(src_ready), 1);
            j.src   = src_ready[1] ? 1 : 0;
            j.route = rt[j.src];
            j.edur  = abort_plan ? 2 : ((du[j.src] == 0) ? 1 : int'(du[j.src]));
            j.legal = legal(rt[j.src]);
            j.acc   = cyc;
            sb.push_back(j);
            grants.push_back(j.src);
         end
         prev_en = out_en;
      end
   end

   task automatic issue(input int s, input logic [RW-1:0] r, input logic [DUR_W-1:0] d,
                        output int waited);
      rt[s] = r;
      du[s] = d;
      src_valid[s] = 1'b1;
      waited = 0;
      #1;
      while (!src_ready[s] && waited < 300) begin
         @(posedge clk); #2;
         waited++;
      end
      chk("grant_wait_bound", waited < 300, 1);
      @(posedge clk); #1;
      src_valid[s] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_wait_bound", n < 1000, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_flow();
      int n;
      n = 0;
      while (!out_en && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("flow_wait_bound", n < 50, 1);
   endtask

   initial begin
      int  n;
      bit  saw_done;
      rt[0] = '0; rt[1] = '0; du[0] = '0; du[1] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_a", sw_cfg_a, 0);
      chk("rst_cfg_b", sw_cfg_b, 0);
      chk("rst_out", {out_sel, out_en, busy, done, done_src, err}, 0);
      chk("rst_ready", src_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Both sources requesting continuously: grants must alternate from Source1.
      grants.delete();
      rt[0] = 10'b01_01_01_10_01; du[0] = 8'd2;
      rt[1] = 10'b11_01_01_01_01; du[1] = 8'd2;
      src_valid = 2'b11;
      n = 0;
      while (grants.size() < 4 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      src_valid = 2'b00;
      chk("alt_grant_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("alt_grant_order", grants[i], i % 2);
      wait_idle();

      issue(0, 10'b01_01_01_01_10, 8'd3, n);
      chk("t1_ready_same_cycle", n, 0);
      wait_idle();

      issue(1, 10'b01_01_00_01_10, 8'd3, n);
      chk("closed_err_pulse", err, 1);
      chk("closed_no_busy", busy, 0);
      chk("closed_cfg_b", sw_cfg_b, 0);
      @(posedge clk); #1;
      chk("closed_err_one_cycle", err, 0);
      issue(0, 10'b01_01_01_01_11, 8'd1, n);
      chk("s1_immediate_grant", n, 0);
      wait_idle();

      issue(0, 10'b01_11_01_10_01, 8'd2, n);
      chk("two_unit_err", err, 1);
      chk("two_unit_no_busy", busy, 0);
      @(posedge clk); #1;
      chk("two_unit_err_one_cycle", err, 0);

      issue(1, 10'b01_01_10_01_01, 8'd0, n);
      wait_idle();

      abort_plan = 1'b1;
      issue(0, 10'b01_01_01_01_10, 8'd10, n);
      abort_plan = 1'b0;
      wait_flow();
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      chk("abort_out_en_drop", out_en, 0);
      wait_idle();

      issue(0, 10'b01_01_01_01_10, 8'd10, n);
      wait_flow();
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      chk("midrst_out_en", out_en, 0);
      chk("midrst_cfg", {sw_cfg_a, sw_cfg_b}, 0);
      chk("midrst_busy", busy, 0);
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      chk("midrst_no_done", saw_done, 0);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
